// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Credit-based instruction fetch queue between the PC/imem stage
//               and decode, with one-cycle memory latency and flush support.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic        flush,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic          r_inflight;
  logic [63:0]   r_inflight_pc;

  logic [63:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_pop_upd;
  logic [CW:0]   w_occ;

  assign id_valid  = !rst && (r_count != '0);
  assign w_pop     = id_valid && id_ready;
  // Entries already owned plus the one returning, minus the one leaving now.
  assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign imem_req  = !rst && !flush && (w_occ < DEPTH_OCC);
  assign pc_stall  = !rst && !flush && !imem_req;
  assign imem_addr = pc_in;

  assign w_push    = !rst && !flush && r_inflight;
  assign w_pop_upd = w_pop && !flush;

  assign id_pc     = r_pc_mem[r_head];
  assign id_inst   = r_inst_mem[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (flush) begin
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_inflight_pc <= pc_in;
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop_upd) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_push, w_pop_upd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; it is invisible while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= r_inflight_pc;
      r_inst_mem[r_tail] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire
